// File: rtl/retire_stage.sv
// ---------------------------------------------------------------------------
// retire_stage
//   Commit stage that sits directly after the reorder buffer. When the ROB
//   head entry is valid and complete, this block retires it:
//     - writes the architectural register file,
//     - squashes and redirects fetch on a mispredicted (taken) branch,
//     - detects halt,
//     - counts retirements.
//   After a squash, retirement is held off for SQUASH_DRAIN_CYCLES cycles.
//
//   Every effect is registered, so outputs appear the cycle after the fire.
//
// Optional feature macro: RETIRE_PERF_COUNT_EN
//   defined     -> retired_count is a live 32-bit retirement counter
//   not defined -> retired_count is tied to 0 (no counter flops)
//
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   head_valid/complete      ROB head allocated / result available
//   head_tag                 ROB index of the head entry
//   head_reg_idx/value       destination register and result value
//   head_PC/NPC              instruction PC and resolved next PC
//   head_take_branch         branch resolved taken (mispredict, predict-not-taken)
//   head_halt                head is a halt instruction
//   rf_wr_en/idx/data        architectural register file write port
//   squash_signal            one-cycle flush pulse
//   redirect_pc              fetch target, valid while squash_signal=1
//   retire_valid/PC/tag      information about the instruction retired last cycle
//   halted                   sticky halt indicator
//   retired_count            retirement performance counter
// ---------------------------------------------------------------------------
module retire_stage #(
  parameter int ROB_SIZE            = 32,
  parameter int XLEN                = 32,
  parameter int SQUASH_DRAIN_CYCLES = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        head_valid,
  input  logic                        head_complete,
  input  logic [$clog2(ROB_SIZE)-1:0] head_tag,
  input  logic [4:0]                  head_reg_idx,
  input  logic [XLEN-1:0]             head_value,
  input  logic [XLEN-1:0]             head_PC,
  input  logic [XLEN-1:0]             head_NPC,
  input  logic                        head_take_branch,
  input  logic                        head_halt,
  output logic                        rf_wr_en,
  output logic [4:0]                  rf_wr_idx,
  output logic [XLEN-1:0]             rf_wr_data,
  output logic                        squash_signal,
  output logic [XLEN-1:0]             redirect_pc,
  output logic                        retire_valid,
  output logic [XLEN-1:0]             retire_PC,
  output logic [$clog2(ROB_SIZE)-1:0] retire_tag,
  output logic                        halted,
  output logic [31:0]                 retired_count
);

  localparam int TAG_W = $clog2(ROB_SIZE);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [3:0] DRAIN_LOAD = 4'(SQUASH_DRAIN_CYCLES);

  logic [1:0]       r_state;
  logic [3:0]       r_drain_cnt;
  logic             r_rf_wr_en;
  logic [4:0]       r_rf_wr_idx;
  logic [XLEN-1:0]  r_rf_wr_data;
  logic             r_squash;
  logic [XLEN-1:0]  r_redirect_pc;
  logic             r_retire_valid;
  logic [XLEN-1:0]  r_retire_pc;
  logic [TAG_W-1:0] r_retire_tag;
  logic             r_halted;

  logic w_fire;
  logic w_writes_rf;
  logic w_mispredict;
  logic w_halt_fire;

  assign w_fire       = (r_state == ST_RUN) && head_valid && head_complete;
  // x0 is hardwired zero, so it retires without a register write
  assign w_writes_rf  = w_fire && (head_reg_idx != 5'd0);
  // halt takes priority over a taken branch: no squash on a halting fire
  assign w_mispredict = w_fire && head_take_branch && !head_halt;
  assign w_halt_fire  = w_fire && head_halt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_halt_fire) begin
            r_state <= ST_HALTED;
          end else if (w_mispredict) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          // leaving at a count of 1 gives exactly DRAIN_LOAD blocked cycles
          if (r_drain_cnt <= 4'd1) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= 4'd0;
          end else begin
            r_drain_cnt <= r_drain_cnt - 4'd1;
          end
        end
        ST_HALTED: r_state <= ST_HALTED;
        default: begin
          r_state     <= ST_RUN;
          r_drain_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Retirement outputs: zero in any cycle not preceded by a fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rf_wr_en     <= 1'b0;
      r_rf_wr_idx    <= '0;
      r_rf_wr_data   <= '0;
      r_squash       <= 1'b0;
      r_redirect_pc  <= '0;
      r_retire_valid <= 1'b0;
      r_retire_pc    <= '0;
      r_retire_tag   <= '0;
      r_halted       <= 1'b0;
    end else begin
      r_rf_wr_en     <= w_writes_rf;
      r_rf_wr_idx    <= w_writes_rf  ? head_reg_idx : 5'd0;
      r_rf_wr_data   <= w_writes_rf  ? head_value   : '0;
      r_squash       <= w_mispredict;
      r_redirect_pc  <= w_mispredict ? head_NPC     : '0;
      r_retire_valid <= w_fire;
      r_retire_pc    <= w_fire       ? head_PC      : '0;
      r_retire_tag   <= w_fire       ? head_tag     : '0;
      r_halted       <= r_halted || w_halt_fire;
    end
  end

`ifdef RETIRE_PERF_COUNT_EN
  logic [31:0] r_retired_count;

  // No fire is possible in HALTED, so the counter freezes there naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_retired_count <= 32'd0;
    end else if (w_fire) begin
      r_retired_count <= r_retired_count + 32'd1;
    end
  end

  assign retired_count = r_retired_count;
`else
  assign retired_count = 32'd0;
`endif

  assign rf_wr_en      = r_rf_wr_en;
  assign rf_wr_idx     = r_rf_wr_idx;
  assign rf_wr_data    = r_rf_wr_data;
  assign squash_signal = r_squash;
  assign redirect_pc   = r_redirect_pc;
  assign retire_valid  = r_retire_valid;
  assign retire_PC     = r_retire_pc;
  assign retire_tag    = r_retire_tag;
  assign halted        = r_halted;

endmodule

// File: tb/tb_retire_stage.sv
// ---------------------------------------------------------------------------
// tb_retire_stage
//   Self-checking bench for retire_stage. A behavioural model tracks whether
//   retirement is allowed (halted flag, earliest cycle at which retirement
//   may resume after a squash) and predicts every output after each edge.
//   Directed steps follow the test plan, then a randomized phase runs.
// ---------------------------------------------------------------------------
module tb_retire_stage;

  localparam int ROB_SIZE = 32;
  localparam int XLEN     = 32;
  localparam int DRAIN    = 2;
  localparam int TAG_W    = $clog2(ROB_SIZE);

  logic             clock = 1'b0;
  logic             reset;
  logic             head_valid;
  logic             head_complete;
  logic [TAG_W-1:0] head_tag;
  logic [4:0]       head_reg_idx;
  logic [XLEN-1:0]  head_value;
  logic [XLEN-1:0]  head_PC;
  logic [XLEN-1:0]  head_NPC;
  logic             head_take_branch;
  logic             head_halt;
  logic             rf_wr_en;
  logic [4:0]       rf_wr_idx;
  logic [XLEN-1:0]  rf_wr_data;
  logic             squash_signal;
  logic [XLEN-1:0]  redirect_pc;
  logic             retire_valid;
  logic [XLEN-1:0]  retire_PC;
  logic [TAG_W-1:0] retire_tag;
  logic             halted;
  logic [31:0]      retired_count;

  retire_stage #(
    .ROB_SIZE(ROB_SIZE), .XLEN(XLEN), .SQUASH_DRAIN_CYCLES(DRAIN)
  ) dut (
    .clock(clock), .reset(reset),
    .head_valid(head_valid), .head_complete(head_complete),
    .head_tag(head_tag), .head_reg_idx(head_reg_idx),
    .head_value(head_value), .head_PC(head_PC), .head_NPC(head_NPC),
    .head_take_branch(head_take_branch), .head_halt(head_halt),
    .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
    .squash_signal(squash_signal), .redirect_pc(redirect_pc),
    .retire_valid(retire_valid), .retire_PC(retire_PC),
    .retire_tag(retire_tag), .halted(halted),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          cyc      = 0;   // index of the next clock edge
  int          m_resume = 0;   // first edge index at which a fire is allowed
  bit          m_halted = 1'b0;
  logic [31:0] m_count  = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input bit c, input logic [TAG_W-1:0] tag,
                       input logic [4:0] idx, input logic [31:0] val,
                       input logic [31:0] pc, input logic [31:0] npc,
                       input bit tb, input bit h);
    head_valid       = v;
    head_complete    = c;
    head_tag         = tag;
    head_reg_idx     = idx;
    head_value       = val;
    head_PC          = pc;
    head_NPC         = npc;
    head_take_branch = tb;
    head_halt        = h;
  endtask

  // One clock edge: predict from the inputs, step, compare every output.
  task automatic tick();
    bit fire, wr, sq;
    fire = !reset && !m_halted && (cyc >= m_resume) && head_valid && head_complete;
    wr   = fire && (head_reg_idx != 5'd0);
    sq   = fire && head_take_branch && !head_halt;
    if (reset) begin
      m_halted = 1'b0;
      m_resume = 0;
      m_count  = 32'd0;
    end else begin
      if (fire && head_halt) m_halted = 1'b1;
      if (sq) m_resume = cyc + DRAIN + 1;
`ifdef RETIRE_PERF_COUNT_EN
      if (fire) m_count = m_count + 32'd1;
`endif
    end
    @(posedge clock);
    #1;
    chk("retire_valid", 32'(retire_valid), 32'(fire));
    chk("retire_PC",    retire_PC,         fire ? head_PC : 32'd0);
    chk("retire_tag",   32'(retire_tag),   fire ? 32'(head_tag) : 32'd0);
    chk("rf_wr_en",     32'(rf_wr_en),     32'(wr));
    // data/index of an x0 retirement is left unconstrained
    if (!fire || wr) begin
      chk("rf_wr_idx",  32'(rf_wr_idx),    wr ? 32'(head_reg_idx) : 32'd0);
      chk("rf_wr_data", rf_wr_data,        wr ? head_value : 32'd0);
    end
    chk("squash",       32'(squash_signal), 32'(sq));
    chk("redirect_pc",  redirect_pc,        sq ? head_NPC : 32'd0);
    chk("halted",       32'(halted),        32'(m_halted));
    chk("retired_count", retired_count,     m_count);
    $display("edge %0d: rst=%0b v=%0b c=%0b idx=%0d tb=%0b h=%0b -> rv=%0b wr=%0b sq=%0b halted=%0b cnt=%0d",
             cyc, reset, head_valid, head_complete, head_reg_idx, head_take_branch,
             head_halt, retire_valid, rf_wr_en, squash_signal, halted, retired_count);
    cyc++;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, '0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0);
    tick();
    tick();
    reset = 1'b0;

    // idle, then a stall (valid but not complete)
    tick();
    drive(1, 0, 5'd3, 5'd7, 32'h55, 32'h80, 32'h84, 0, 0);
    tick();

    // plain fire to x5
    drive(1, 1, 5'd4, 5'd5, 32'hDEADBEEF, 32'h100, 32'h104, 0, 0);
    tick();
    chk("tp_wdata", rf_wr_data, 32'hDEADBEEF);
    chk("tp_pc", retire_PC, 32'h100);

    // fire to x0
    drive(1, 1, 5'd5, 5'd0, 32'h1234, 32'h104, 32'h108, 0, 0);
    tick();

    // taken branch: squash, then two drain cycles with head held, then resume
    drive(1, 1, 5'd6, 5'd1, 32'h104, 32'h108, 32'h2000, 1, 0);
    tick();
    chk("tp_redirect", redirect_pc, 32'h2000);
    drive(1, 1, 5'd7, 5'd2, 32'h77, 32'h2000, 32'h2004, 0, 0);
    for (int i = 0; i < 3; i++) tick();

    // halt with take_branch: no squash, then absorbing for 10 cycles
    drive(1, 1, 5'd8, 5'd3, 32'h99, 32'h2004, 32'h3000, 1, 1);
    tick();
    drive(1, 1, 5'd9, 5'd4, 32'hAA, 32'h2008, 32'h200C, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // seven back-to-back fires, one to x0
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 5'(i), (i == 3) ? 5'd0 : 5'(i + 10), 32'(i * 3 + 1),
            32'(32'h400 + i * 4), 32'(32'h404 + i * 4), 0, 0);
      tick();
    end

    // reset asserted during DRAIN
    drive(1, 1, 5'd20, 5'd9, 32'h1, 32'h500, 32'h600, 1, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // randomized phase
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            5'($urandom), 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
            $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
